// File: rtl/multi_cycle_cpu_top.sv
// Multi-cycle MIPS-subset processor shell: a unified byte-lane memory shared
// by the core and an AXI4-Lite slave used by the host to load and inspect it.

// Multi-cycle core: fetch, decode, execute, memory, write-back.
module simple_cpu (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  input  logic [31:0] Instruction,
  output logic [31:0] Address,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [31:0] Write_data,
  output logic [3:0]  Write_strb,
  input  logic [31:0] Read_data
);
  typedef enum logic [4:0] {
    S_FETCH  = 5'b00001,
    S_DECODE = 5'b00010,
    S_EXEC   = 5'b00100,
    S_MEM    = 5'b01000,
    S_WB     = 5'b10000
  } state_t;

  state_t current_state, next_state;
  logic [31:0] pc_reg, ir_reg, a_reg, b_reg, alu_reg, mdr_reg;
  logic [31:0] rf [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, dest;
  logic [31:0] sext_imm, zext_imm, alu_result;
  logic        is_lw, is_sw, is_branch, is_jump, is_jr, writes_reg, branch_taken;

  assign opcode   = ir_reg[31:26];
  assign rs       = ir_reg[25:21];
  assign rt       = ir_reg[20:16];
  assign rd       = ir_reg[15:11];
  assign shamt    = ir_reg[10:6];
  assign funct    = ir_reg[5:0];
  assign sext_imm = {{16{ir_reg[15]}}, ir_reg[15:0]};
  assign zext_imm = {16'h0000, ir_reg[15:0]};

  assign is_lw      = (opcode == 6'h23);
  assign is_sw      = (opcode == 6'h2B);
  assign is_branch  = (opcode == 6'h04) || (opcode == 6'h05);
  assign is_jump    = (opcode == 6'h02);
  assign is_jr      = (opcode == 6'h00) && (funct == 6'h08);
  // Unknown opcodes fall through as no-ops rather than clobbering rt
  assign writes_reg = ((opcode == 6'h00) && !is_jr) || is_lw || (opcode == 6'h09) ||
                      (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0F);
  assign dest       = (opcode == 6'h00) ? rd : rt;
  assign branch_taken = ((opcode == 6'h04) && (a_reg == b_reg)) ||
                        ((opcode == 6'h05) && (a_reg != b_reg));

  assign PC         = pc_reg;
  assign Address    = alu_reg;
  assign Write_data = b_reg;
  assign Write_strb = {4{MemWrite}};

  // ALU: R-type functions plus immediate arithmetic/logic and address generation
  always_comb begin
    alu_result = 32'h0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h21:   alu_result = a_reg + b_reg;
          6'h23:   alu_result = a_reg - b_reg;
          6'h24:   alu_result = a_reg & b_reg;
          6'h25:   alu_result = a_reg | b_reg;
          6'h26:   alu_result = a_reg ^ b_reg;
          6'h2A:   alu_result = {31'h0, $signed(a_reg) < $signed(b_reg)};
          6'h00:   alu_result = b_reg << shamt;
          default: alu_result = 32'h0;
        endcase
      end
      6'h09, 6'h23, 6'h2B: alu_result = a_reg + sext_imm;
      6'h0C:   alu_result = a_reg & zext_imm;
      6'h0D:   alu_result = a_reg | zext_imm;
      6'h0F:   alu_result = {ir_reg[15:0], 16'h0000};
      default: alu_result = 32'h0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) current_state <= S_FETCH;
    else     current_state <= next_state;
  end

  // Next-state and memory strobes
  always_comb begin
    next_state = current_state;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    case (current_state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC: begin
        if (is_lw || is_sw)  next_state = S_MEM;
        else if (writes_reg) next_state = S_WB;
        else                 next_state = S_FETCH;
      end
      S_MEM: begin
        if (is_lw) begin
          MemRead    = 1'b1;
          next_state = S_WB;
        end else begin
          MemWrite   = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_WB:    next_state = S_FETCH;
      default: next_state = S_FETCH;
    endcase
  end

  // Datapath registers and register file, advanced per state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg  <= 32'h0;
      ir_reg  <= 32'h0;
      a_reg   <= 32'h0;
      b_reg   <= 32'h0;
      alu_reg <= 32'h0;
      mdr_reg <= 32'h0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else begin
      case (current_state)
        S_FETCH: begin
          ir_reg <= Instruction;
          pc_reg <= pc_reg + 32'd4;
        end
        S_DECODE: begin
          a_reg <= rf[rs];
          b_reg <= rf[rt];
        end
        S_EXEC: begin
          alu_reg <= alu_result;
          if (is_branch && branch_taken) pc_reg <= pc_reg + {sext_imm[29:0], 2'b00};
          else if (is_jump)              pc_reg <= {pc_reg[31:28], ir_reg[25:0], 2'b00};
          else if (is_jr)                pc_reg <= a_reg;
        end
        S_MEM:   if (is_lw) mdr_reg <= Read_data;
        S_WB:    if (dest != 5'd0) rf[dest] <= is_lw ? mdr_reg : alu_reg;
        default: ;
      endcase
    end
  end
endmodule

// Top shell: memory, AXI4-Lite slave and the core instance.
module multi_cycle_cpu_top #(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_rst,
  input  logic [31:0] simple_cpu_axi_if_araddr,
  input  logic        simple_cpu_axi_if_arvalid,
  output logic        simple_cpu_axi_if_arready,
  output logic [31:0] simple_cpu_axi_if_rdata,
  output logic [1:0]  simple_cpu_axi_if_rresp,
  output logic        simple_cpu_axi_if_rvalid,
  input  logic        simple_cpu_axi_if_rready,
  input  logic [31:0] simple_cpu_axi_if_awaddr,
  input  logic        simple_cpu_axi_if_awvalid,
  output logic        simple_cpu_axi_if_awready,
  input  logic [31:0] simple_cpu_axi_if_wdata,
  input  logic [3:0]  simple_cpu_axi_if_wstrb,
  input  logic        simple_cpu_axi_if_wvalid,
  output logic        simple_cpu_axi_if_wready,
  output logic [1:0]  simple_cpu_axi_if_bresp,
  output logic        simple_cpu_axi_if_bvalid,
  input  logic        simple_cpu_axi_if_bready
);
  localparam int DEPTH = 1 << MEM_AW;

  logic [31:0] PC, Address, Write_data, Instruction, Read_data;
  logic        MemWrite, MemRead;
  logic [3:0]  Write_strb;

  logic              core_rst, core_we, aw_fire, ar_fire;
  logic              rvalid_reg, bvalid_reg;
  logic [31:0]       rdata_reg, ar_word;
  logic [MEM_AW-1:0] pc_idx, core_idx, ar_idx, aw_idx;
  logic              unused_bits;

  assign core_rst = cpu_rst | ~resetn;

  simple_cpu u_simple_cpu (
    .clk         (clk),
    .rst         (core_rst),
    .PC          (PC),
    .Instruction (Instruction),
    .Address     (Address),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .Write_data  (Write_data),
    .Write_strb  (Write_strb),
    .Read_data   (Read_data)
  );

  // Word indices: byte offset and upper bits dropped, so addresses alias
  assign pc_idx   = PC[MEM_AW+1:2];
  assign core_idx = Address[MEM_AW+1:2];
  assign ar_idx   = simple_cpu_axi_if_araddr[MEM_AW+1:2];
  assign aw_idx   = simple_cpu_axi_if_awaddr[MEM_AW+1:2];

  assign core_we = MemWrite & ~core_rst;
  assign aw_fire = simple_cpu_axi_if_awvalid & simple_cpu_axi_if_wvalid & ~bvalid_reg;
  assign ar_fire = simple_cpu_axi_if_arvalid & ~rvalid_reg;

  assign simple_cpu_axi_if_awready = aw_fire;
  assign simple_cpu_axi_if_wready  = aw_fire;
  assign simple_cpu_axi_if_bvalid  = bvalid_reg;
  assign simple_cpu_axi_if_bresp   = 2'b00;
  assign simple_cpu_axi_if_arready = ~rvalid_reg;
  assign simple_cpu_axi_if_rvalid  = rvalid_reg;
  assign simple_cpu_axi_if_rdata   = rdata_reg;
  assign simple_cpu_axi_if_rresp   = 2'b00;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      // Byte-lane write; the AXI assignment comes last so it wins a same-word collision
      always_ff @(posedge clk) begin
        if (core_we && Write_strb[gi])
          lane_mem[core_idx] <= Write_data[8*gi +: 8];
        if (aw_fire && simple_cpu_axi_if_wstrb[gi])
          lane_mem[aw_idx] <= simple_cpu_axi_if_wdata[8*gi +: 8];
      end

      assign Instruction[8*gi +: 8] = lane_mem[pc_idx];
      assign Read_data[8*gi +: 8]   = lane_mem[core_idx];
      assign ar_word[8*gi +: 8]     = lane_mem[ar_idx];
    end
  endgenerate

  // Write response: raised after an accepted AW+W pair, cleared on bready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)           bvalid_reg <= 1'b0;
    else if (aw_fire)      bvalid_reg <= 1'b1;
    else if (simple_cpu_axi_if_bready) bvalid_reg <= 1'b0;
  end

  // Read data: captured on address acceptance and held until rready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= 32'h0;
    end else if (ar_fire) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= ar_word;
    end else if (simple_cpu_axi_if_rready) begin
      rvalid_reg <= 1'b0;
    end
  end

  assign unused_bits = ^{MemRead, PC[31:MEM_AW+2], PC[1:0], Address[31:MEM_AW+2], Address[1:0],
                         simple_cpu_axi_if_araddr[31:MEM_AW+2], simple_cpu_axi_if_araddr[1:0],
                         simple_cpu_axi_if_awaddr[31:MEM_AW+2], simple_cpu_axi_if_awaddr[1:0]};
endmodule

// File: tb/tb_multi_cycle_cpu_top.sv
// Bench for multi_cycle_cpu_top: AXI vectors, random traffic vs. a word-map
// model, collision and reset corner cases, and a small program run.
`timescale 1ns/1ps
module tb_multi_cycle_cpu_top;
  logic        clk = 1'b0;
  logic        resetn, cpu_rst;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;

  multi_cycle_cpu_top #(.MEM_AW(10)) dut (
    .clk                       (clk),
    .resetn                    (resetn),
    .cpu_rst                   (cpu_rst),
    .simple_cpu_axi_if_araddr  (araddr),
    .simple_cpu_axi_if_arvalid (arvalid),
    .simple_cpu_axi_if_arready (arready),
    .simple_cpu_axi_if_rdata   (rdata),
    .simple_cpu_axi_if_rresp   (rresp),
    .simple_cpu_axi_if_rvalid  (rvalid),
    .simple_cpu_axi_if_rready  (rready),
    .simple_cpu_axi_if_awaddr  (awaddr),
    .simple_cpu_axi_if_awvalid (awvalid),
    .simple_cpu_axi_if_awready (awready),
    .simple_cpu_axi_if_wdata   (wdata),
    .simple_cpu_axi_if_wstrb   (wstrb),
    .simple_cpu_axi_if_wvalid  (wvalid),
    .simple_cpu_axi_if_wready  (wready),
    .simple_cpu_axi_if_bresp   (bresp),
    .simple_cpu_axi_if_bvalid  (bvalid),
    .simple_cpu_axi_if_bready  (bready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // 4 KB memory: word number modulo 1024
  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'd1024);
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int w;
    logic [31:0] v;
    w = widx(addr);
    v = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    for (int b = 0; b < 4; b++)
      if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
    ref_mem[w] = v;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n = 0;
    while (!(awready && wready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("aw_w_ready", {30'h0, awready, wready}, 32'h3);
    @(posedge clk); #1;
    chk("bvalid_set", 32'(bvalid), 32'h1);
    chk("bresp", 32'(bresp), 32'h0);
    chk("awready_blocked", {30'h0, awready, wready}, 32'h0);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", 32'(bvalid), 32'h1);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    chk("bvalid_clear", 32'(bvalid), 32'h0);
    bready = 1'b0;
    model_write(addr, data, strb);
    $display("AXI WR addr=0x%08h data=0x%08h strb=0x%h", addr, data, strb);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int hold, output logic [31:0] data);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("arready", 32'(arready), 32'h1);
    @(posedge clk); #1;
    chk("rvalid_set", 32'(rvalid), 32'h1);
    chk("rresp", 32'(rresp), 32'h0);
    data = rdata;
    // A competing request stays pending while the response is stalled
    araddr = addr ^ 32'h4;
    if (hold == 0) arvalid = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("rvalid_hold", 32'(rvalid), 32'h1);
      chk("rdata_hold", rdata, data);
      chk("arready_busy", 32'(arready), 32'h0);
    end
    arvalid = 1'b0;
    rready  = 1'b1;
    @(posedge clk); #1;
    chk("rvalid_clear", 32'(rvalid), 32'h0);
    chk("arready_free", 32'(arready), 32'h1);
    rready = 1'b0;
    $display("AXI RD addr=0x%08h data=0x%08h", addr, data);
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] raddr;
    logic [31:0] rexp;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] prog [8];

  initial begin
    #50000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, exp_v, a;
    logic [3:0]  s;
    int          found, w, exp_sum;

    vecs[0] = '{32'h10,  32'hDEADBEEF, 4'hF, 32'h10,       32'hDEADBEEF};
    vecs[1] = '{32'h10,  32'h000000AA, 4'h1, 32'h10,       32'hDEADBEAA};
    vecs[2] = '{32'h10,  32'h00000000, 4'h0, 32'h1010,     32'hDEADBEAA};
    vecs[3] = '{32'h20,  32'h12345678, 4'hF, 32'h1020,     32'h12345678};
    vecs[4] = '{32'h22,  32'hAABBCCDD, 4'hC, 32'h20,       32'hAABB5678};
    vecs[5] = '{32'hFFC, 32'h0BADF00D, 4'hF, 32'hFFFFFFFF, 32'h0BADF00D};
    vecs[6] = '{32'h24,  32'hCAFEBABE, 4'hF, 32'h24,       32'hCAFEBABE};
    vecs[7] = '{32'h24,  32'h11223344, 4'h6, 32'h7024,     32'hCA2233BE};

    prog[0] = enc_i(6'h09, 5'd0, 5'd1, 16'd0);      // addiu $1,$0,0
    prog[1] = enc_i(6'h09, 5'd0, 5'd2, 16'd5);      // addiu $2,$0,5
    prog[2] = enc_r(5'd1, 5'd2, 5'd1, 6'h21);       // addu  $1,$1,$2
    prog[3] = enc_i(6'h09, 5'd2, 5'd2, 16'hFFFF);   // addiu $2,$2,-1
    prog[4] = enc_i(6'h05, 5'd2, 5'd0, 16'hFFFD);   // bne   $2,$0,-3
    prog[5] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0040);   // sw    $1,0x40($0)
    prog[6] = enc_i(6'h2B, 5'd0, 5'd0, 16'h000C);   // sw    $0,12($0)
    prog[7] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);   // beq   $0,$0,-1

    resetn = 1'b0; cpu_rst = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;

    // Reset state
    #100;
    chk("rst_rvalid",  32'(rvalid),  32'h0);
    chk("rst_bvalid",  32'(bvalid),  32'h0);
    chk("rst_rdata",   rdata,        32'h0);
    chk("rst_arready", 32'(arready), 32'h1);
    chk("rst_awready", 32'(awready), 32'h0);
    chk("rst_wready",  32'(wready),  32'h0);
    chk("rst_pc",      dut.PC,       32'h0);
    chk("rst_state",   32'(dut.u_simple_cpu.current_state), 32'h1);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("held_pc", dut.PC, 32'h0);
    $display("RESET done pc=0x%08h", dut.PC);

    // Table-driven AXI vectors
    for (int i = 0; i < 8; i++) begin
      axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, (i == 0) ? 3 : 0);
      axi_read(vecs[i].raddr, (i == 2) ? 5 : 0, rd);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rexp);
    end

    // Same-word read and write in one cycle: read sees the old word
    axi_write(32'h30, 32'hAAAA0000, 4'hF, 0);
    @(negedge clk);
    araddr = 32'h30; arvalid = 1'b1;
    awaddr = 32'h30; wdata = 32'h55555555; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("coll_rvalid", 32'(rvalid), 32'h1);
    chk("coll_bvalid", 32'(bvalid), 32'h1);
    chk("coll_old_data", rdata, 32'hAAAA0000);
    rready = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; bready = 1'b0;
    model_write(32'h30, 32'h55555555, 4'hF);
    $display("COLLISION rd=0x%08h", 32'hAAAA0000);
    axi_read(32'h30, 0, rd);
    chk("coll_new_data", rd, 32'h55555555);

    // Random traffic over a 16-word window with aliasing address bits
    for (int i = 0; i < 16; i++)
      axi_write(32'h100 + 32'(i * 4), $urandom, 4'hF, 0);
    for (int i = 0; i < 60; i++) begin
      w = int'($urandom_range(0, 15));
      a = ($urandom & 32'hFFFFF000) | (32'h100 + 32'(w * 4)) | ($urandom & 32'h3);
      if ($urandom_range(0, 1) == 1) begin
        s = 4'($urandom_range(0, 15));
        axi_write(a, $urandom, s, int'($urandom_range(0, 2)));
      end else begin
        axi_read(a, int'($urandom_range(0, 3)), rd);
        exp_v = ref_mem[widx(a)];
        chk("rand_rdata", rd, exp_v);
      end
    end

    // Program run
    for (int i = 0; i < 8; i++)
      axi_write(32'(i * 4), prog[i], 4'hF, 0);
    exp_sum = 0;
    for (int v = 5; v > 0; v--) exp_sum += v;
    @(negedge clk);
    cpu_rst = 1'b0;
    found = 0;
    for (int c = 0; c < 3000 && found == 0; c++) begin
      @(negedge clk);
      if (dut.MemWrite === 1'b1 && dut.Address === 32'h0C) found = 1;
    end
    chk("done_seen", 32'(found), 32'h1);
    chk("done_wdata", dut.Write_data, 32'h0);
    chk("done_wstrb", 32'(dut.Write_strb), 32'hF);
    $display("PROGRAM done found=%0d", found);
    repeat (3) @(negedge clk);
    cpu_rst = 1'b1;
    @(posedge clk); #1;
    chk("cpurst_pc", dut.PC, 32'h0);
    chk("cpurst_state", 32'(dut.u_simple_cpu.current_state), 32'h1);
    axi_read(32'h0C, 0, rd);
    chk("done_word", rd, 32'h0);
    axi_read(32'h40, 0, rd);
    chk("sum_word", rd, 32'(exp_sum));

    // resetn pulse during an outstanding read
    @(negedge clk);
    araddr = 32'h40; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("pre_rst_rvalid", 32'(rvalid), 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("pulse_rvalid", 32'(rvalid), 32'h0);
    chk("pulse_rdata", rdata, 32'h0);
    chk("pulse_arready", 32'(arready), 32'h1);
    $display("RESET pulse rvalid=%0d", rvalid);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    axi_read(32'h40, 0, rd);
    chk("post_rst_sum", rd, 32'(exp_sum));
    axi_read(32'h104, 0, rd);
    chk("post_rst_word", rd, ref_mem[widx(32'h104)]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_cycle_cpu_top.md
Name: multi_cycle_cpu_top

Overview:
Top-level shell of the multi-cycle MIPS-subset processor. It holds a unified instruction/data memory and instantiates the existing multi-cycle core as instance u_simple_cpu. It also provides an AXI4-Lite slave through which the host loads programs and inspects memory. The host drives cpu_rst high while loading a program, then releases it to run the program.

Parameters:
MEM_AW, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KB).

Ports:
clk  input  1  single system clock; every register is on its rising edge.
resetn  input  1  asynchronous active-low reset for the whole block.
cpu_rst  input  1  active-high hold-reset for the core only; the AXI slave and memory stay operational.
simple_cpu_axi_if_araddr  input  32  AXI read address.
simple_cpu_axi_if_arvalid  input  1  AXI read address valid.
simple_cpu_axi_if_arready  output  1  AXI read address ready.
simple_cpu_axi_if_rdata  output  32  AXI read data.
simple_cpu_axi_if_rresp  output  2  read response; constant 2'b00.
simple_cpu_axi_if_rvalid  output  1  read data valid.
simple_cpu_axi_if_rready  input  1  read data ready.
simple_cpu_axi_if_awaddr  input  32  AXI write address.
simple_cpu_axi_if_awvalid  input  1  write address valid.
simple_cpu_axi_if_awready  output  1  write address ready.
simple_cpu_axi_if_wdata  input  32  write data.
simple_cpu_axi_if_wstrb  input  4  byte strobes.
simple_cpu_axi_if_wvalid  input  1  write data valid.
simple_cpu_axi_if_wready  output  1  write data ready.
simple_cpu_axi_if_bresp  output  2  write response; constant 2'b00.
simple_cpu_axi_if_bvalid  output  1  write response valid.
simple_cpu_axi_if_bready  input  1  write response ready.

Behaviour:
- Core reset: core rst = cpu_rst | ~resetn.
- Core interface nets at the top use the names PC, Address, MemWrite, MemRead, Write_data, Write_strb, Instruction and Read_data.
- Core fetch state is encoded as 5'b00001 in its current_state register.
- Memory array: 2^MEM_AW words of 32 bits. Contents are not reset.
- Word index = byte address [MEM_AW+1:2]. Upper address bits are ignored, so addresses alias. Bits [1:0] are ignored.
- Core ports: Instruction = mem[PC index] and Read_data = mem[Address index] are combinational reads.
- A core write occurs at the clock edge when MemWrite=1, updating each byte i where Write_strb[i]=1.
- Core writes are ignored while the core is held in reset.
- AXI write channel:
  - awready = wready = awvalid & wvalid & ~bvalid (combinational). AW and W are always accepted together.
  - On acceptance, mem[awaddr index] is updated with strobe masking at that edge, and bvalid is set the next cycle.
  - bvalid is held until bready is sampled high, then cleared.
- AXI read channel:
  - arready = ~rvalid.
  - On arvalid & arready, rdata is registered from mem[araddr index] and rvalid is set the next cycle.
  - rdata and rvalid are held stable until rready is sampled high, then rvalid is cleared.
- Collisions:
  - A read and a write to the same word in the same cycle returns the old data.
  - If a core write and an AXI write hit the same word in the same cycle, the AXI write's enabled bytes win. The AXI port is used only while the core is in reset.
- Reset (resetn low, asynchronous): rvalid=0, bvalid=0, rdata=0, and the core goes to its reset state (PC=0, fetch state).
  - Outputs derived combinationally therefore read arready=1 and awready=wready=0.
  - A handshake in progress is dropped.
- cpu_rst asserted mid-run: the core restarts from PC=0 on release. Memory keeps its contents.
- Program-completion convention: the benchmark signals done by having the core store word 0x00000000 to byte address 0x0C (MemWrite=1, Address=0x0C, Write_data=0).
- With all AXI inputs tied to 0 the block must run the preloaded memory image deterministically with no X on PC, Address, MemRead or MemWrite after reset.

Test Plan:
- Assert resetn=0 for 100 ns with AXI inputs 0 -> rvalid=0, bvalid=0, arready=1, awready=0; core PC=0 after release.
- With cpu_rst=1, write 0xDEADBEEF with strb 0xF to 0x10 -> awready and wready pulse in the same cycle; bvalid rises next cycle and holds with bready=0; it clears the cycle after bready=1.
- Read 0x10 -> rvalid next cycle with rdata=0xDEADBEEF. Then write 0x000000AA with strb 0x1 to 0x10 and read back -> 0xDEADBEAA. Read 0x1010 with MEM_AW=10 -> alias returns the same value.
- Read with rready=0 for 5 cycles -> rvalid and rdata stable, arready=0 throughout; a new arvalid is not accepted until after the rready handshake.
- Load a program (addiu/sw loop ending with sw $zero,12($zero)) while cpu_rst=1, then release cpu_rst -> core eventually shows MemWrite=1, Address=0x0C, Write_data=0, Write_strb=0xF; after reasserting cpu_rst, an AXI read of 0x0C returns 0.
- Pulse resetn low during an outstanding AXI read -> rvalid drops immediately; after release, a new read completes normally and memory contents are unchanged.
